// File: rtl/attn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : attn_pkg
//  Brief    : Shared types and constants for attention-head shared units.
//  Revision : 1.0 - initial release
// ============================================================================
package attn_pkg;

  // Operand width of the leading-one position detector.
  localparam int D_W   = 32;
  localparam int POS_W = $clog2(D_W);

  // Requester ID field carried in responses; sized for the four lanes of the
  // attention head that share one detector.
  localparam int LOPD_ID_W = 2;

  // Response word held in the output stage and seen by consumers.
  typedef struct packed {
    logic [POS_W-1:0]     pos;
    logic                 zero;
    logic [LOPD_ID_W-1:0] id;
  } lopd_resp_t;

endpackage : attn_pkg
`default_nettype wire

// File: rtl/lopd.sv
`default_nettype none
// ============================================================================
//  Module   : lopd
//  Brief    : Combinational leading-one position detector (32-bit).
//             pos is the index of the most-significant set bit; 0 when the
//             operand is all-zero, which is flagged separately by zero.
//  Revision : 1.0 - initial release
// ============================================================================
module lopd
  import attn_pkg::*;
(
  input  logic [D_W-1:0]   data,
  output logic [POS_W-1:0] pos,
  output logic             zero
);

  // Scan upward so the highest set bit is the last one recorded.
  always_comb begin
    pos = '0;
    for (int i = 0; i < D_W; i++) begin
      if (data[i]) pos = POS_W'(i);
    end
  end

  assign zero = ~|data;

endmodule : lopd
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin arbiter. The search starts at ptr and
//             wraps; grant is one-hot (all-zero when en is low or nothing
//             requests), grant_idx is the encoded winner.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic w_found;

  // First requester at or after ptr (modulo NUM_REQ) wins.
  always_comb begin
    w_found   = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && req[(int'(ptr) + k) % NUM_REQ]) begin
        w_found   = 1'b1;
        grant_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  // Expand the winner to one-hot, qualified by the enable.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = en && w_found && (grant_idx == ID_W'(i));
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/lopd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : lopd_arbiter
//  Brief    : Shares one leading-one position detector between NUM_REQ
//             requesters. Round-robin grant into a capture register, lopd
//             between registers, registered response with valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module lopd_arbiter
  import attn_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*D_W-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [POS_W-1:0]       resp_pos,
  output logic                   resp_zero,
  output logic [ID_W-1:0]        resp_id
);

  // Capture stage
  logic             r_s1_valid;
  logic [D_W-1:0]   r_s1_data;
  logic [ID_W-1:0]  r_s1_id;
  logic [ID_W-1:0]  r_ptr;

  // Output stage
  logic             r_resp_valid;
  lopd_resp_t       r_resp;

  logic             w_s2_free;
  logic             w_s1_free;
  logic             w_advance;
  logic             w_accept;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_gidx;
  logic [D_W-1:0]   w_sel_data;
  logic [POS_W-1:0] w_pos;
  logic             w_zero;

  assign w_s2_free = !r_resp_valid || resp_ready;
  assign w_s1_free = !r_s1_valid || w_s2_free;
  assign w_advance = r_s1_valid && w_s2_free;
  assign w_accept  = |w_grant;

  // Gating with rst_n keeps req_ready low while reset is asserted so no
  // requester believes an operand was taken on the reset edge.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (r_ptr),
    .en        (w_s1_free && rst_n),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  assign req_ready  = w_grant;
  assign w_sel_data = req_data[int'(w_gidx) * D_W +: D_W];

  lopd u_lopd (
    .data (r_s1_data),
    .pos  (w_pos),
    .zero (w_zero)
  );

  // Pipeline registers and round-robin pointer update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_data    <= '0;
      r_s1_id      <= '0;
      r_ptr        <= '0;
      r_resp_valid <= 1'b0;
      r_resp       <= '0;
    end else begin
      if (w_advance) begin
        r_resp_valid <= 1'b1;
        r_resp.pos   <= w_pos;
        r_resp.zero  <= w_zero;
        r_resp.id    <= LOPD_ID_W'(r_s1_id);
      end else if (resp_ready) begin
        r_resp_valid <= 1'b0;
      end

      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_data  <= w_sel_data;
        r_s1_id    <= w_gidx;
        r_ptr      <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
      end else if (w_advance) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_pos   = r_resp.pos;
  assign resp_zero  = r_resp.zero;
  assign resp_id    = ID_W'(r_resp.id);

endmodule : lopd_arbiter
`default_nettype wire

// File: tb/tb_lopd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lopd_arbiter
//  Brief    : Self-checking bench for lopd_arbiter: directed scenarios plus a
//             randomized run against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lopd_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic [4:0]    resp_pos;
  logic          resp_zero;
  logic [1:0]    resp_id;

  int n_checks = 0;
  int n_fail   = 0;
  bit hold_en  = 1'b0;

  lopd_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_pos   (resp_pos),
    .resp_zero  (resp_zero),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester obligation: a pending operand stays valid and unchanged.
  for (genvar gi = 0; gi < N; gi++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (!hold_en || !rst_n)
      (req_valid[gi] && !req_ready[gi]) |=> (req_valid[gi] && $stable(req_data[gi*32 +: 32])));
  end

  // Reference leading-one position: floor(log2(d)), 0 for d == 0.
  function automatic int refpos(input logic [31:0] d);
    if (d == 32'd0) return 0;
    return $clog2({32'd0, d} + 64'd1) - 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0; req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", resp_valid); end
    n_checks++; if (resp_pos !== 5'd0) begin n_fail++; $display("FAIL reset_pos: got %0d want 0", resp_pos); end
    n_checks++; if (resp_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %0b want 0", resp_zero); end
    n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", resp_id); end
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_data[2*32 +: 32] = 32'h0001_0000;
    req_valid = 4'b0100; resp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %0b want 0", resp_valid); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", resp_valid); end
    n_checks++; if (resp_pos !== 5'd16) begin n_fail++; $display("FAIL single_pos: got %0d want 16", resp_pos); end
    n_checks++; if (resp_zero !== 1'b0) begin n_fail++; $display("FAIL single_zero: got %0b want 0", resp_zero); end
    n_checks++; if (resp_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d want 2", resp_id); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0b want 0", resp_valid); end
  endtask

  task automatic test_extremes();
    logic [31:0] xd [3];
    int          xp [3];
    bit          xz [3];
    xd = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
    xp = '{0, 31, 0};
    xz = '{1'b1, 1'b0, 1'b0};
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_data[k*32 +: 32] = xd[k];
      req_valid = '0; req_valid[k] = 1'b1;
      #1;
      n_checks++; if (req_ready !== req_valid) begin n_fail++; $display("FAIL extreme_ready[%0d]: got %b want %b", k, req_ready, req_valid); end
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      @(posedge clk); @(negedge clk);
      n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL extreme_valid[%0d]: got %0b want 1", k, resp_valid); end
      n_checks++; if (resp_pos !== 5'(xp[k])) begin n_fail++; $display("FAIL extreme_pos[%0d]: got %0d want %0d", k, resp_pos, xp[k]); end
      n_checks++; if (resp_zero !== xz[k]) begin n_fail++; $display("FAIL extreme_zero[%0d]: got %0b want %0b", k, resp_zero, xz[k]); end
      n_checks++; if (resp_id !== 2'(k)) begin n_fail++; $display("FAIL extreme_id[%0d]: got %0d want %0d", k, resp_id, k); end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*32 +: 32] = 32'd1 << (i + 4);
    req_valid = 4'b1111; resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_checks++; if (req_ready !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL fair_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
      if (c >= 2) begin
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL fair_valid[%0d]: got %0b want 1", c, resp_valid); end
        n_checks++; if (resp_id !== 2'((c - 2) % 4)) begin n_fail++; $display("FAIL fair_id[%0d]: got %0d want %0d", c, resp_id, (c - 2) % 4); end
        n_checks++; if (resp_pos !== 5'(4 + (c - 2) % 4)) begin n_fail++; $display("FAIL fair_pos[%0d]: got %0d want %0d", c, resp_pos, 4 + (c - 2) % 4); end
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [3:0] erdy [10];
    bit         evld [10];
    int         eid  [10];
    erdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
             4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    evld = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    eid  = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*32 +: 32] = 32'd1 << (i + 8);
    req_valid = 4'b1111; resp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) resp_ready = 1'b1;
      #1;
      n_checks++; if (req_ready !== erdy[c]) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want %b", c, req_ready, erdy[c]); end
      n_checks++; if (resp_valid !== evld[c]) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b want %0b", c, resp_valid, evld[c]); end
      if (evld[c]) begin
        n_checks++; if (resp_id !== 2'(eid[c])) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d want %0d", c, resp_id, eid[c]); end
        n_checks++; if (resp_pos !== 5'(8 + eid[c])) begin n_fail++; $display("FAIL bp_pos[%0d]: got %0d want %0d", c, resp_pos, 8 + eid[c]); end
      end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_pointer_skip();
    do_reset();
    resp_ready = 1'b1;
    req_data[0*32 +: 32] = 32'h0000_0100;
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL skip_first: got %b want 0001", req_ready); end
    @(posedge clk); @(negedge clk);
    req_data[0*32 +: 32] = 32'h4000_0000;
    req_data[3*32 +: 32] = 32'h0002_0000;
    req_valid = 4'b1001;
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL skip_grant3: got %b want 1000", req_ready); end
    @(posedge clk); @(negedge clk);
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL skip_grant0: got %b want 0001", req_ready); end
    n_checks++; if (resp_id !== 2'd0 || resp_pos !== 5'd8 || resp_valid !== 1'b1) begin n_fail++; $display("FAIL skip_resp0: got v%0b id%0d pos%0d want v1 id0 pos8", resp_valid, resp_id, resp_pos); end
    @(posedge clk); @(negedge clk);
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_ptr1: got %b want 0010", req_ready); end
    n_checks++; if (resp_id !== 2'd3 || resp_pos !== 5'd17 || resp_valid !== 1'b1) begin n_fail++; $display("FAIL skip_resp3: got v%0b id%0d pos%0d want v1 id3 pos17", resp_valid, resp_id, resp_pos); end
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    n_checks++; if (resp_id !== 2'd0 || resp_pos !== 5'd30 || resp_valid !== 1'b1) begin n_fail++; $display("FAIL skip_resp0b: got v%0b id%0d pos%0d want v1 id0 pos30", resp_valid, resp_id, resp_pos); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL skip_drain: got %0b want 0", resp_valid); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*32 +: 32] = 32'd1 << (i + 12);
    req_valid = 4'b1111; resp_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0) begin n_fail++; $display("FAIL mid_fill: got v%0b id%0d want v1 id0", resp_valid, resp_id); end
    rst_n = 1'b0; req_valid = '0;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready_rst: got %b want 0000", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b want 0", resp_valid); end
    n_checks++; if (resp_pos !== 5'd0 || resp_id !== 2'd0 || resp_zero !== 1'b0) begin n_fail++; $display("FAIL mid_resp: got pos%0d id%0d z%0b want 0", resp_pos, resp_id, resp_zero); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready: got %b want 0000", req_ready); end
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d]: got %0b want 0", c, resp_valid); end
    end
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr: got %b want 0001", req_ready); end
    req_valid = '0;
  endtask

  typedef struct {
    int e;
    int pos;
    bit zero;
    int id;
  } exp_t;

  task automatic test_random();
    exp_t        q[$];
    bit [3:0]    pend;
    logic [31:0] pdata [N];
    int          mptr, ecount, g, sh;
    bit          exp_vld, can;
    logic [3:0]  exp_rdy;
    do_reset();
    q.delete(); pend = '0; mptr = 0; ecount = 0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    hold_en = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && c < 270 && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          sh = $urandom_range(0, 33);
          pdata[i] = (sh >= 32) ? 32'd0 : ($urandom >> sh);
        end
        req_valid[i] = pend[i];
        req_data[i*32 +: 32] = pdata[i];
      end
      resp_ready = (c >= 270) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      exp_vld = (q.size() > 0) && (ecount >= q[0].e + 1);
      n_checks++; if (resp_valid !== exp_vld) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", c, resp_valid, exp_vld); end
      if (exp_vld) begin
        n_checks++;
        if (resp_pos !== 5'(q[0].pos) || resp_zero !== q[0].zero || resp_id !== 2'(q[0].id)) begin
          n_fail++;
          $display("FAIL rnd_resp[%0d]: got pos%0d z%0b id%0d want pos%0d z%0b id%0d", c, resp_pos, resp_zero, resp_id, q[0].pos, q[0].zero, q[0].id);
        end
      end
      can = (q.size() < 2) || resp_ready;
      g = -1;
      if (can) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); end
      if (exp_vld && resp_ready) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{e: ecount + 1, pos: refpos(pdata[g]), zero: (pdata[g] == 32'd0), id: g});
        pend[g] = 1'b0;
        mptr = (g + 1) % N;
      end
      @(posedge clk);
      ecount++;
      @(negedge clk);
    end
    hold_en = 1'b0;
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b0;
    test_reset();
    test_single();
    test_extremes();
    test_fairness();
    test_backpressure();
    test_pointer_skip();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lopd_arbiter
`default_nettype wire

// File: doc/lopd_arbiter.md
Name: lopd_arbiter

Overview:
- Shares one combinational `lopd` (leading-one position detector, D_W=32) between NUM_REQ requesters in the attention head, e.g. softmax max/normalisation lanes.
- Round-robin grant, registered input stage, `lopd` between registers, registered output stage with valid/ready backpressure.
- Each response returns the leading-one position, a zero flag and the requester ID.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- D_W, 32, operand width; fixed at 32 because `lopd` is hard-wired to 32 bits
- ID_W, $clog2(NUM_REQ), requester ID width (derived localparam)
- POS_W, $clog2(D_W), position width (derived localparam)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_data  in  NUM_REQ*D_W  operands; requester i occupies bits [i*D_W +: D_W]
- req_ready  out  NUM_REQ  one-hot or zero; operand i is accepted when req_valid[i] && req_ready[i]
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts when resp_valid && resp_ready
- resp_pos  out  POS_W  index of the most-significant set bit of the operand
- resp_zero  out  1  operand was all-zero (resp_pos=0 in this case)
- resp_id  out  ID_W  requester index that supplied the operand

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - s1_valid=0, s2_valid=0, rr_ptr=0.
  - Outputs: resp_valid=0, resp_pos=0, resp_zero=0, resp_id=0, req_ready=0.
  - Reset mid-operation discards all in-flight operands; no response is produced for them.
- Stage 1 (capture): registers s1_data, s1_id, s1_valid.
- Stage 2 (output): registers resp_pos, resp_zero, resp_id, resp_valid.
  - resp_pos = lopd(s1_data); resp_zero = (s1_data == 0).
- Stall logic:
  - s2_free = !resp_valid || resp_ready.
  - s1_free = !s1_valid || s2_free.
  - Stage 1 advances into stage 2 when s1_valid && s2_free.
  - resp_valid clears when the response is consumed and nothing advances into stage 2.
- Arbitration:
  - Combinational, over requesters with req_valid=1.
  - Search starts at rr_ptr and wraps: order rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...
  - req_ready[g] = s1_free for the winner g; 0 for all others.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- On acceptance: s1 <= {req_data[g], g}; rr_ptr <= (g+1) mod NUM_REQ.
  - With no acceptance, rr_ptr holds.
- Latency and throughput:
  - Accepted at edge T -> resp_valid=1 after edge T+1 (two registers).
  - Throughput is 1 operand/cycle when resp_ready is held high.
- Backpressure:
  - While resp_valid && !resp_ready, stage 2 holds.
  - Stage 1 holds if occupied; req_ready is all-zero once stage 1 is full.
  - resp_* must stay stable while stalled.
- Simultaneous events:
  - Consumption at stage 2, stage 1 advance and a new acceptance may all happen in the same cycle; no bubble is inserted.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,...
  - Each requester waits at most NUM_REQ-1 grants of others between its own grants.
- Requester obligation: a requester must hold req_valid/req_data stable until accepted (checked by assertion in the bench).
- `lopd` is instantiated, not re-implemented.

Decomposition:
- Shared package `attn_pkg`:
  - D_W=32 constant.
  - POS_W localparam.
  - typedef `lopd_resp_t` {pos, zero, id}, used as the stage-2 register and by consumers.
- Sub-module `rr_arbiter`: parameter NUM_REQ; inputs req, ptr, en; output one-hot grant and encoded grant index.
  - Reusable by other shared units in the attention head.
- `lopd` is instantiated once in `lopd_arbiter`.

Test Plan:
- Single request: reset, then req 2 only, data 0x0001_0000, resp_ready=1.
  - req_ready=4'b0100 in the acceptance cycle.
  - 2 cycles later: resp_valid=1, pos=16, zero=0, id=2.
- Zero and extremes: data 0x0000_0000 -> pos=0, zero=1; 0x8000_0000 -> pos=31; 0x0000_0001 -> pos=0, zero=0.
- Fairness: all 4 requesters continuously valid with distinct data 1<<(i+4) each, resp_ready=1.
  - Response ids 0,1,2,3,0,... with pos 4,5,6,7,...
  - One response per cycle after 2-cycle fill.
- Backpressure: all valid, resp_ready=0 for 5 cycles.
  - Exactly 2 operands accepted (stage 1 + stage 2); req_ready=0 afterwards.
  - resp_* stable during the stall.
  - On release, no loss and no duplication; order preserved.
- Pointer skip: rr_ptr=1, only req 0 and req 3 valid -> grant 3 first, then 0; rr_ptr becomes 1.
- Reset mid-flight: 2 operands in flight, then rst_n=0 for one edge.
  - Next cycle: resp_valid=0, req_ready=0, rr_ptr=0.
  - No stale response appears after rst_n returns to 1.
